phy_rx_fifo: RTL and testbench
==============================

PHY_RX_FIFO -- requirements
Module: phy_rx_fifo

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MAX_NUM_LANES, 4, lane count
- DATA_WIDTH, 32, packed bits per lane per row
- DEPTH, 8, FIFO rows; power of two, >=2
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, sole clock
- rst_ni, in, 1, asynchronous active-low reset
- phy_link_up_i, in, 1, link up; low flushes block
- pipe_width_i, in, 6, PIPE width in bits: 8, 16 or 32
- num_active_lanes_i, in, 6, active lanes
- pipe_data_i, in, 32*MAX_NUM_LANES, per-lane PIPE data; lane n at [32n+:32], LSB-aligned
- pipe_valid_i, in, MAX_NUM_LANES, per-lane beat valid
- pipe_datak_i, in, 4*MAX_NUM_LANES, per-lane K flags; one per byte
- pipe_sync_header_i, in, 2*MAX_NUM_LANES, per-lane 128b/130b sync header
- phy_fifo_rd_en_i, in, 1, pop request
- phy_fifo_empty_o, out, 1, FIFO empty
- data_o, out, DATA_WIDTH*MAX_NUM_LANES, popped row
- data_valid_o, out, MAX_NUM_LANES, popped lane-valid mask
- data_k_o, out, 4*MAX_NUM_LANES, popped K flags
- sync_header_o, out, 2*MAX_NUM_LANES, popped sync headers
- fifo_level_o, out, clog2(DEPTH)+1, occupied rows
- overflow_o, out, 1, sticky: row dropped because FIFO full
- lane_err_o, out, 1, single-cycle pulse: active lanes not valid together

Function
REQ-003 Effective lanes L = MAX_NUM_LANES if num_active_lanes_i > MAX_NUM_LANES, else num_active_lanes_i; L=0 -> no accumulation.
REQ-004 Beats per word B = 32/pipe_width_i (4, 2, 1); any other width -> beats ignored, no accumulation.
REQ-005 Beat accepted when phy_link_up_i=1 and pipe_valid_i[n]=1 for every n<L.
REQ-006 Some but not all of lanes n<L valid -> beat dropped, beat counter and accumulator cleared, lane_err_o high for that one cycle.
REQ-007 Beat k (0..B-1) of lane n lands in accumulator bits [32n + k*W +: W] (W = pipe_width_i); matching K flags in [4n + k*W/8 +: W/8]; first-received byte in bits [7:0].
REQ-008 Sync header captured from beat 0 only.
REQ-009 Beat B-1 accepted -> completed row (lanes >=L: data/K/header zero, valid bit 0; lanes <L valid bit 1) written to FIFO in the same clock edge; beat counter returns to 0.
REQ-010 pipe_width_i or num_active_lanes_i change while beat counter is nonzero -> partial word discarded, counter cleared, no lane_err_o.
REQ-011 Write succeeds when FIFO not full, or full with an accepted pop in the same cycle.
REQ-012 Write when full with no pop -> row dropped, overflow_o set; stays set until reset or phy_link_up_i low.
REQ-013 Pop accepted when phy_fifo_rd_en_i=1 and phy_fifo_empty_o=0; data_o/data_valid_o/data_k_o/sync_header_o show the popped row from the next cycle (one-cycle read latency) and hold until the next accepted pop.
REQ-014 phy_fifo_rd_en_i while empty -> ignored, outputs hold, level unchanged.
REQ-015 phy_fifo_empty_o and fifo_level_o are registered and reflect writes/pops on the cycle after the edge; simultaneous write+pop leaves level unchanged.
REQ-016 Pointers wrap modulo DEPTH; full = level==DEPTH.
REQ-017 phy_link_up_i low -> next edge clears pointers, level, beat counter, accumulator and overflow_o; data_o holds; beats ignored while low.

Reset
REQ-018 rst_ni low asynchronously clears pointers, level, beat counter, accumulator, overflow_o, lane_err_o, data_o, data_valid_o, data_k_o, sync_header_o; phy_fifo_empty_o=1.
REQ-019 Reset asserted mid-word or mid-pop discards all state; no row is output after release until new beats complete a word.

Verification
REQ-020 Gen1 x4, width 8, lane n bytes 0x10n..0x13n over 4 beats -> one row; lane0 word 0x13121110; empty drops 1 cycle later; rd_en -> data_o valid next cycle, data_valid_o=4'hF.
REQ-021 width 16, L=2, lane1 valid missing on beat 1 -> lane_err_o pulse, no row written, next 2 clean beats produce a row with data_valid_o=4'b0011.
REQ-022 DEPTH=8, 9 rows written, no pops -> level=8, overflow_o=1, 9th row lost; 8 pops return rows 1..8 in order, then empty=1.
REQ-023 Full FIFO, write and pop same cycle -> level stays 8, overflow_o stays 0.
REQ-024 phy_link_up_i low with level=5 and beat counter=2 -> next cycle level=0, empty=1, overflow_o=0; rd_en while empty -> data_o unchanged.
REQ-025 rst_ni asserted mid-stream between edges -> outputs cleared immediately without a clock edge; empty=1.

Source files
------------

// File: rtl/phy_rx_fifo_if.sv
// PIPE receive lanes into the FIFO and popped rows out of it.
interface phy_rx_fifo_if #(
   parameter int unsigned MAX_NUM_LANES = 4,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH         = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic                              phy_link_up_i;
   logic [5:0]                        pipe_width_i;
   logic [5:0]                        num_active_lanes_i;
   logic [32*MAX_NUM_LANES-1:0]       pipe_data_i;
   logic [MAX_NUM_LANES-1:0]          pipe_valid_i;
   logic [4*MAX_NUM_LANES-1:0]        pipe_datak_i;
   logic [2*MAX_NUM_LANES-1:0]        pipe_sync_header_i;
   logic                              phy_fifo_rd_en_i;
   logic                              phy_fifo_empty_o;
   logic [DATA_WIDTH*MAX_NUM_LANES-1:0] data_o;
   logic [MAX_NUM_LANES-1:0]          data_valid_o;
   logic [4*MAX_NUM_LANES-1:0]        data_k_o;
   logic [2*MAX_NUM_LANES-1:0]        sync_header_o;
   logic [LW-1:0]                     fifo_level_o;
   logic                              overflow_o;
   logic                              lane_err_o;

   modport slave (
      input  phy_link_up_i, pipe_width_i, num_active_lanes_i, pipe_data_i,
             pipe_valid_i, pipe_datak_i, pipe_sync_header_i, phy_fifo_rd_en_i,
      output phy_fifo_empty_o, data_o, data_valid_o, data_k_o, sync_header_o,
             fifo_level_o, overflow_o, lane_err_o
   );

   modport master (
      output phy_link_up_i, pipe_width_i, num_active_lanes_i, pipe_data_i,
             pipe_valid_i, pipe_datak_i, pipe_sync_header_i, phy_fifo_rd_en_i,
      input  phy_fifo_empty_o, data_o, data_valid_o, data_k_o, sync_header_o,
             fifo_level_o, overflow_o, lane_err_o
   );
endinterface

// File: rtl/phy_rx_fifo.sv
// Packs narrow PIPE beats from all active lanes into 32-bit-per-lane rows
// and buffers the rows in a FIFO with a one-cycle registered read port.
module phy_rx_fifo #(
   parameter int unsigned MAX_NUM_LANES = 4,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH         = 8
) (
   input logic          clk_i,
   input logic          rst_ni,
   phy_rx_fifo_if.slave bus
);
   localparam int unsigned NL  = MAX_NUM_LANES;
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned RDW = DATA_WIDTH * NL;

   logic [5:0]      lanes_eff;
   logic [NL-1:0]   lane_act;
   logic            width_ok;
   logic [1:0]      last_beat;
   logic [1:0]      bshift;
   logic [1:0]      bmask;
   logic            any_v, all_v, cfg_chg, run;
   logic            beat_acc, beat_err, row_done;

   logic [1:0]      beat_q, beat_d;
   logic [5:0]      width_q, lanes_q;
   logic [32*NL-1:0] acc_q, acc_d, acc_wr;
   logic [4*NL-1:0] acck_q, acck_d, acck_wr;
   logic [2*NL-1:0] hdr_q, hdr_d, hdr_wr;

   logic [RDW-1:0]  row_data;
   logic [NL-1:0]   row_valid;
   logic [4*NL-1:0] row_k;
   logic [2*NL-1:0] row_hdr;

   logic [RDW-1:0]  mem_data_q [DEPTH];
   logic [NL-1:0]   mem_valid_q [DEPTH];
   logic [4*NL-1:0] mem_k_q [DEPTH];
   logic [2*NL-1:0] mem_hdr_q [DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            empty_q, empty_d;
   logic            ovf_q, ovf_d;
   logic            lane_err_q, lane_err_d;
   logic            full, pop, push_ok;

   logic [RDW-1:0]  out_data_q, out_data_d;
   logic [NL-1:0]   out_valid_q, out_valid_d;
   logic [4*NL-1:0] out_k_q, out_k_d;
   logic [2*NL-1:0] out_hdr_q, out_hdr_d;

   // Lane/width decode: bshift is log2(bytes per beat).
   always_comb begin
      lanes_eff = (bus.num_active_lanes_i > 6'(NL)) ? 6'(NL) : bus.num_active_lanes_i;
      for (int unsigned n = 0; n < NL; n++) begin
         lane_act[n] = (lanes_eff > 6'(n));
      end
      width_ok  = 1'b1;
      last_beat = 2'd0;
      bshift    = 2'd0;
      bmask     = 2'd0;
      case (bus.pipe_width_i)
         6'd8:    begin last_beat = 2'd3; bshift = 2'd0; bmask = 2'd0; end
         6'd16:   begin last_beat = 2'd1; bshift = 2'd1; bmask = 2'd1; end
         6'd32:   begin last_beat = 2'd0; bshift = 2'd2; bmask = 2'd3; end
         default: width_ok = 1'b0;
      endcase
   end

   // Beat qualification; a config change mid-word discards without flagging.
   always_comb begin
      any_v    = |(bus.pipe_valid_i & lane_act);
      all_v    = (lanes_eff != 6'd0) && ((bus.pipe_valid_i & lane_act) == lane_act);
      cfg_chg  = (beat_q != 2'd0) &&
                 ((bus.pipe_width_i != width_q) || (bus.num_active_lanes_i != lanes_q));
      run      = bus.phy_link_up_i && width_ok && !cfg_chg;
      beat_acc = run && all_v;
      beat_err = run && any_v && !all_v;
      row_done = beat_acc && (beat_q == last_beat);
   end

   // Merge the current beat into the accumulator; beat 0 starts from zero.
   always_comb begin
      acc_wr  = (beat_q == 2'd0) ? '0 : acc_q;
      acck_wr = (beat_q == 2'd0) ? '0 : acck_q;
      hdr_wr  = (beat_q == 2'd0) ? '0 : hdr_q;
      for (int unsigned n = 0; n < NL; n++) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (lane_act[n] && ((2'(b) >> bshift) == beat_q)) begin
               acc_wr[32*n + 8*b +: 8] = bus.pipe_data_i[32*n + 8*32'(2'(b) & bmask) +: 8];
               acck_wr[4*n + b]        = bus.pipe_datak_i[4*n + 32'(2'(b) & bmask)];
            end
         end
         if (lane_act[n] && (beat_q == 2'd0)) begin
            hdr_wr[2*n +: 2] = bus.pipe_sync_header_i[2*n +: 2];
         end
      end
   end

   always_comb begin
      for (int unsigned n = 0; n < NL; n++) begin
         row_valid[n]                      = lane_act[n];
         row_data[DATA_WIDTH*n +: DATA_WIDTH] =
            lane_act[n] ? DATA_WIDTH'(acc_wr[32*n +: 32]) : '0;
         row_k[4*n +: 4]                   = lane_act[n] ? acck_wr[4*n +: 4] : 4'd0;
         row_hdr[2*n +: 2]                 = lane_act[n] ? hdr_wr[2*n +: 2] : 2'd0;
      end
   end

   // Next-state for beat counter, accumulator and FIFO bookkeeping.
   always_comb begin
      beat_d      = beat_q;
      acc_d       = acc_q;
      acck_d      = acck_q;
      hdr_d       = hdr_q;
      full        = (level_q == LW'(DEPTH));
      pop         = bus.phy_link_up_i && bus.phy_fifo_rd_en_i && !empty_q;
      push_ok     = row_done && (!full || pop);
      ovf_d       = ovf_q | (row_done && full && !pop);
      wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d     = level_q + LW'(push_ok) - LW'(pop);
      lane_err_d  = beat_err;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_k_d     = out_k_q;
      out_hdr_d   = out_hdr_q;

      if (!bus.phy_link_up_i || cfg_chg || beat_err) begin
         beat_d = 2'd0;
         acc_d  = '0;
         acck_d = '0;
         hdr_d  = '0;
      end else if (beat_acc) begin
         if (row_done) begin
            beat_d = 2'd0;
            acc_d  = '0;
            acck_d = '0;
            hdr_d  = '0;
         end else begin
            beat_d = beat_q + 2'd1;
            acc_d  = acc_wr;
            acck_d = acck_wr;
            hdr_d  = hdr_wr;
         end
      end

      if (pop) begin
         out_data_d  = mem_data_q[rd_ptr_q];
         out_valid_d = mem_valid_q[rd_ptr_q];
         out_k_d     = mem_k_q[rd_ptr_q];
         out_hdr_d   = mem_hdr_q[rd_ptr_q];
      end

      if (!bus.phy_link_up_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
      end
      empty_d = (level_d == '0);
   end

   // Row storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_data_q[wr_ptr_q]  <= row_data;
         mem_valid_q[wr_ptr_q] <= row_valid;
         mem_k_q[wr_ptr_q]     <= row_k;
         mem_hdr_q[wr_ptr_q]   <= row_hdr;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_q      <= 2'd0;
         width_q     <= 6'd0;
         lanes_q     <= 6'd0;
         acc_q       <= '0;
         acck_q      <= '0;
         hdr_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
         lane_err_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= '0;
         out_k_q     <= '0;
         out_hdr_q   <= '0;
      end else begin
         beat_q      <= beat_d;
         width_q     <= bus.pipe_width_i;
         lanes_q     <= bus.num_active_lanes_i;
         acc_q       <= acc_d;
         acck_q      <= acck_d;
         hdr_q       <= hdr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
         lane_err_q  <= lane_err_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_k_q     <= out_k_d;
         out_hdr_q   <= out_hdr_d;
      end
   end

   assign bus.phy_fifo_empty_o = empty_q;
   assign bus.data_o           = out_data_q;
   assign bus.data_valid_o     = out_valid_q;
   assign bus.data_k_o         = out_k_q;
   assign bus.sync_header_o    = out_hdr_q;
   assign bus.fifo_level_o     = level_q;
   assign bus.overflow_o       = ovf_q;
   assign bus.lane_err_o       = lane_err_q;

endmodule

// File: tb/tb_phy_rx_fifo.sv
// Bench for phy_rx_fifo: table of lane/width configurations plus hand-built
// sequences for lane errors, config changes, overflow, link drop and reset.
module tb_phy_rx_fifo;
   localparam int NL    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   phy_rx_fifo_if #(.MAX_NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   phy_rx_fifo #(.MAX_NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [127:0] d;
      logic [3:0]   v;
      logic [15:0]  k;
      logic [7:0]   h;
   } row_t;

   typedef struct {
      int          width;
      int          lanes;
      logic [3:0]  exp_valid;
      logic [31:0] exp_lane0;
      logic [31:0] exp_lane1;
      logic [31:0] exp_lane3;
      logic [15:0] exp_k;
      logic [7:0]  exp_hdr;
   } vec_t;

   row_t sbq[$];
   row_t last_pop;
   vec_t vecs[4];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_level = 0;
   logic m_ovf   = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lane_byte(input int n, input int j, input int tag);
      return 8'((n + 1) * 16 + j + 4 * tag);
   endfunction

   // Reference row built directly from lane byte pattern, independent of beat slicing.
   function automatic row_t model_row(input int lanes, input int tag);
      row_t r;
      int   l;
      l = (lanes > NL) ? NL : lanes;
      r.d = '0; r.v = '0; r.k = '0; r.h = '0;
      for (int n = 0; n < l; n++) begin
         for (int j = 0; j < 4; j++) r.d[32*n + 8*j +: 8] = lane_byte(n, j, tag);
         r.k[4*n]       = 1'b1;
         r.h[2*n +: 2]  = (n % 2 == 0) ? 2'b01 : 2'b10;
         r.v[n]         = 1'b1;
      end
      return r;
   endfunction

   task automatic set_beat(input int w, input int lanes, input int k, input int tag,
                           input logic [3:0] vmask);
      int bpb;
      int j;
      bpb = w / 8;
      bus.pipe_width_i       = 6'(w);
      bus.num_active_lanes_i = 6'(lanes);
      bus.pipe_data_i        = '0;
      bus.pipe_datak_i       = '0;
      bus.pipe_sync_header_i = '1;
      for (int n = 0; n < NL; n++) begin
         for (int i = 0; i < bpb; i++) begin
            j = k * bpb + i;
            bus.pipe_data_i[32*n + 8*i +: 8] = lane_byte(n, j, tag);
            bus.pipe_datak_i[4*n + i]        = (j == 0);
         end
         if (k == 0) bus.pipe_sync_header_i[2*n +: 2] = (n % 2 == 0) ? 2'b01 : 2'b10;
      end
      bus.pipe_valid_i = vmask;
   endtask

   task automatic model_push(input row_t r);
      if (m_level < DEPTH) begin
         sbq.push_back(r);
         m_level++;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic drive_word(input int w, input int lanes, input int tag);
      int nb;
      nb = 32 / w;
      for (int k = 0; k < nb; k++) begin
         set_beat(w, lanes, k, tag, 4'hF);
         tick();
      end
      bus.pipe_valid_i = '0;
      model_push(model_row(lanes, tag));
   endtask

   task automatic pop_check(input string name);
      row_t e;
      bus.phy_fifo_rd_en_i = 1'b1;
      tick();
      bus.phy_fifo_rd_en_i = 1'b0;
      if (sbq.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty at pop", name);
      end else begin
         e = sbq.pop_front();
         m_level--;
         last_pop = e;
         chk({name, ".data"},  bus.data_o,        e.d);
         chk({name, ".valid"}, bus.data_valid_o,  e.v);
         chk({name, ".k"},     bus.data_k_o,      e.k);
         chk({name, ".hdr"},   bus.sync_header_o, e.h);
         chk({name, ".level"}, bus.fifo_level_o,  m_level);
      end
   endtask

   initial begin
      row_t e;
      vecs[0] = '{8,  4, 4'hF, 32'h13121110, 32'h23222120, 32'h43424140, 16'h1111, 8'h99};
      vecs[1] = '{16, 2, 4'h3, 32'h13121110, 32'h23222120, 32'h00000000, 16'h0011, 8'h09};
      vecs[2] = '{32, 1, 4'h1, 32'h13121110, 32'h00000000, 32'h00000000, 16'h0001, 8'h01};
      vecs[3] = '{32, 9, 4'hF, 32'h13121110, 32'h23222120, 32'h43424140, 16'h1111, 8'h99};
      last_pop = model_row(0, 0);

      bus.phy_link_up_i      = 1'b1;
      bus.pipe_width_i       = 6'd8;
      bus.num_active_lanes_i = 6'd4;
      bus.pipe_data_i        = '0;
      bus.pipe_valid_i       = '0;
      bus.pipe_datak_i       = '0;
      bus.pipe_sync_header_i = '0;
      bus.phy_fifo_rd_en_i   = 1'b0;
      #12;
      chk("rst.empty",    bus.phy_fifo_empty_o, 1'b1);
      chk("rst.level",    bus.fifo_level_o,     0);
      chk("rst.data",     bus.data_o,           0);
      chk("rst.valid",    bus.data_valid_o,     0);
      chk("rst.overflow", bus.overflow_o,       1'b0);
      chk("rst.lane_err", bus.lane_err_o,       1'b0);
      rst_n = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 4; i++) begin
         drive_word(vecs[i].width, vecs[i].lanes, 0);
         chk($sformatf("vec%0d.empty_after_write", i), bus.phy_fifo_empty_o, 1'b0);
         chk($sformatf("vec%0d.level", i), bus.fifo_level_o, m_level);
         pop_check($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.lane0", i), bus.data_o[31:0],   vecs[i].exp_lane0);
         chk($sformatf("vec%0d.lane1", i), bus.data_o[63:32],  vecs[i].exp_lane1);
         chk($sformatf("vec%0d.lane3", i), bus.data_o[127:96], vecs[i].exp_lane3);
         chk($sformatf("vec%0d.vmask", i), bus.data_valid_o,   vecs[i].exp_valid);
         chk($sformatf("vec%0d.kmask", i), bus.data_k_o,       vecs[i].exp_k);
         chk($sformatf("vec%0d.hdrs", i),  bus.sync_header_o,  vecs[i].exp_hdr);
         chk($sformatf("vec%0d.empty_after_pop", i), bus.phy_fifo_empty_o, 1'b1);
      end

      // Zero active lanes: nothing accumulates.
      for (int k = 0; k < 4; k++) begin
         set_beat(8, 0, k, 3, 4'hF);
         tick();
      end
      bus.pipe_valid_i = '0;
      chk("l0.level",    bus.fifo_level_o, 0);
      chk("l0.lane_err", bus.lane_err_o,   1'b0);

      // Partial lane-valid on beat 1 of a two-beat word.
      set_beat(16, 2, 0, 5, 4'hF);
      tick();
      chk("lerr.beat0", bus.lane_err_o, 1'b0);
      set_beat(16, 2, 1, 5, 4'b0001);
      tick();
      chk("lerr.pulse", bus.lane_err_o,   1'b1);
      chk("lerr.level", bus.fifo_level_o, 0);
      bus.pipe_valid_i = '0;
      tick();
      chk("lerr.pulse_end", bus.lane_err_o,   1'b0);
      chk("lerr.no_row",    bus.fifo_level_o, 0);
      drive_word(16, 2, 6);
      chk("lerr.recover_level", bus.fifo_level_o, m_level);
      pop_check("lerr.row");
      chk("lerr.vmask", bus.data_valid_o, 4'b0011);

      // Width change mid-word discards the partial word.
      set_beat(8, 4, 0, 7, 4'hF);
      tick();
      set_beat(8, 4, 1, 7, 4'hF);
      tick();
      bus.pipe_width_i = 6'd16;
      bus.pipe_valid_i = '0;
      tick();
      chk("cfg.lane_err", bus.lane_err_o,   1'b0);
      chk("cfg.level",    bus.fifo_level_o, 0);
      drive_word(16, 4, 8);
      chk("cfg.row_level", bus.fifo_level_o, m_level);
      pop_check("cfg.row");

      // Nine writes into eight rows: ninth is dropped, overflow sticks.
      for (int t = 1; t <= 9; t++) drive_word(32, 4, t);
      chk("ovf.level",    bus.fifo_level_o, m_level);
      chk("ovf.flag",     bus.overflow_o,   m_ovf);
      chk("ovf.full8",    bus.fifo_level_o, DEPTH);
      for (int p = 0; p < DEPTH; p++) pop_check($sformatf("ovf.pop%0d", p));
      chk("ovf.empty",    bus.phy_fifo_empty_o, 1'b1);
      chk("ovf.sticky",   bus.overflow_o,       1'b1);

      // Link drop clears the sticky flag; then fill and push+pop while full.
      bus.phy_link_up_i = 1'b0;
      tick();
      bus.phy_link_up_i = 1'b1;
      m_ovf = 1'b0;
      m_level = 0;
      sbq.delete();
      chk("link.ovf_clr",  bus.overflow_o,       1'b0);
      chk("link.empty",    bus.phy_fifo_empty_o, 1'b1);
      for (int t = 11; t <= 18; t++) drive_word(32, 4, t);
      chk("full.level", bus.fifo_level_o, DEPTH);
      chk("full.ovf",   bus.overflow_o,   1'b0);
      set_beat(32, 4, 0, 20, 4'hF);
      bus.phy_fifo_rd_en_i = 1'b1;
      tick();
      bus.pipe_valid_i     = '0;
      bus.phy_fifo_rd_en_i = 1'b0;
      e = sbq.pop_front();
      sbq.push_back(model_row(4, 20));
      last_pop = e;
      chk("simul.data",  bus.data_o,       e.d);
      chk("simul.level", bus.fifo_level_o, DEPTH);
      chk("simul.ovf",   bus.overflow_o,   1'b0);

      // Link drop with level 5 and two beats pending.
      for (int p = 0; p < 3; p++) pop_check($sformatf("drain%0d", p));
      chk("drain.level5", bus.fifo_level_o, 5);
      set_beat(8, 4, 0, 21, 4'hF);
      tick();
      set_beat(8, 4, 1, 21, 4'hF);
      tick();
      bus.pipe_valid_i  = '0;
      bus.phy_link_up_i = 1'b0;
      tick();
      bus.phy_link_up_i = 1'b1;
      sbq.delete();
      m_level = 0;
      chk("down.level", bus.fifo_level_o,     0);
      chk("down.empty", bus.phy_fifo_empty_o, 1'b1);
      chk("down.ovf",   bus.overflow_o,       1'b0);
      chk("down.hold",  bus.data_o,           last_pop.d);
      bus.phy_fifo_rd_en_i = 1'b1;
      tick();
      bus.phy_fifo_rd_en_i = 1'b0;
      chk("down.rd_empty_hold", bus.data_o,       last_pop.d);
      chk("down.rd_empty_lvl",  bus.fifo_level_o, 0);
      drive_word(8, 4, 22);
      chk("down.fresh_level", bus.fifo_level_o, m_level);
      pop_check("down.fresh");

      // Asynchronous reset between edges, mid-word and mid-pop.
      drive_word(8, 4, 23);
      set_beat(8, 4, 0, 24, 4'hF);
      tick();
      set_beat(8, 4, 1, 24, 4'hF);
      bus.phy_fifo_rd_en_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.empty", bus.phy_fifo_empty_o, 1'b1);
      chk("arst.level", bus.fifo_level_o,     0);
      chk("arst.data",  bus.data_o,           0);
      chk("arst.valid", bus.data_valid_o,     0);
      chk("arst.k",     bus.data_k_o,         0);
      chk("arst.hdr",   bus.sync_header_o,    0);
      #2;
      bus.pipe_valid_i     = '0;
      bus.phy_fifo_rd_en_i = 1'b0;
      rst_n = 1'b1;
      sbq.delete();
      m_level = 0;
      tick();
      tick();
      chk("arst.still_empty", bus.phy_fifo_empty_o, 1'b1);
      bus.phy_fifo_rd_en_i = 1'b1;
      tick();
      bus.phy_fifo_rd_en_i = 1'b0;
      chk("arst.no_row", bus.data_o, 0);
      drive_word(8, 4, 25);
      chk("arst.new_level", bus.fifo_level_o, m_level);
      pop_check("arst.new_row");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
